// File: rtl/mux_check_pkg.sv
// rtl/mux_check_pkg.sv - shared types, defaults and golden function for the mux response checker
package mux_check_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_NUM_VECTORS = 26;
   localparam int DEF_CNT_W       = 8;

   function automatic logic mux_ref(input logic a, input logic b, input logic s);
      return s ? b : a;
   endfunction

endpackage

// File: rtl/mux_ref_model.sv
// rtl/mux_ref_model.sv - combinational golden model of the 2:1 mux
// Kept separate so the checker shell can be reused for other gate references.
module mux_ref_model
   import mux_check_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic s,
   output logic expected
);

   assign expected = mux_ref(a, b, s);

endmodule

// File: rtl/mux_response_checker.sv
// rtl/mux_response_checker.sv - run-based response monitor for the 2:1 mux (f = s ? b : a)
// Optional first-failure capture enabled by MUX_CHECK_FIRST_FAIL_EN.
module mux_response_checker
   import mux_check_pkg::*;
#(
   parameter int NUM_VECTORS = DEF_NUM_VECTORS,
   parameter int CNT_W       = DEF_CNT_W
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sample_valid,
   input  logic             a,
   input  logic             b,
   input  logic             s,
   input  logic             f,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] vec_count,
   output logic [CNT_W-1:0] err_count,
   output logic             mismatch
`ifdef MUX_CHECK_FIRST_FAIL_EN
   ,
   output logic             first_fail_valid,
   output logic [CNT_W-1:0] first_fail_idx,
   output logic [3:0]       first_fail_vec
`endif
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);

   state_t state;
   state_t state_nxt;

   logic expected;
   logic sample_fail;
   logic run_start;
   logic take;
   logic last_take;

   mux_ref_model u_ref (
      .a        (a),
      .b        (b),
      .s        (s),
      .expected (expected)
   );

   assign sample_fail = (f != expected);
   // start is only honoured outside RUN; a sample on the start cycle is dropped
   assign run_start   = start && (state != RUN);
   assign take        = (state == RUN) && sample_valid;
   assign last_take   = take && (vec_count == LAST_IDX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last_take) state_nxt = DONE;
         DONE:    if (start) state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);
   assign pass = done && (err_count == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_count <= '0;
         err_count <= '0;
         mismatch  <= 1'b0;
      end else begin
         mismatch <= take && sample_fail;
         if (run_start) begin
            vec_count <= '0;
            err_count <= '0;
         end else if (take) begin
            vec_count <= vec_count + 1'b1;
            if (sample_fail && (err_count != '1)) begin
               err_count <= err_count + 1'b1;
            end
         end
      end
   end

`ifdef MUX_CHECK_FIRST_FAIL_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         first_fail_valid <= 1'b0;
         first_fail_idx   <= '0;
         first_fail_vec   <= '0;
      end else if (run_start) begin
         first_fail_valid <= 1'b0;
         first_fail_idx   <= '0;
         first_fail_vec   <= '0;
      end else if (take && sample_fail && !first_fail_valid) begin
         first_fail_valid <= 1'b1;
         first_fail_idx   <= vec_count;
         first_fail_vec   <= {a, b, s, f};
      end
   end
`endif

endmodule

// File: tb/tb_mux_response_checker.sv
// tb/tb_mux_response_checker.sv - directed self-checking bench for mux_response_checker
module tb_mux_response_checker;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic sample_valid = 1'b0;
   logic a = 1'b0;
   logic b = 1'b0;
   logic s = 1'b0;
   logic f = 1'b0;

   logic       m_busy, m_done, m_pass, m_mismatch;
   logic [7:0] m_vec, m_err;
   logic       t_busy, t_done, t_pass, t_mismatch;
   logic [2:0] t_vec, t_err;
`ifdef MUX_CHECK_FIRST_FAIL_EN
   logic       m_ffv, t_ffv;
   logic [7:0] m_ffi;
   logic [2:0] t_ffi;
   logic [3:0] m_ffvec, t_ffvec;
`endif

   int n_tests = 0;
   int n_fail = 0;
   int mm_count = 0;
   bit check_en = 1'b0;

   // behavioural model state, index 0 = default instance, 1 = CNT_W=3/NUM_VECTORS=7
   int NV[2] = '{26, 7};
   int CAP[2] = '{255, 7};
   bit md_run[2];
   bit md_fin[2];
   int md_vec[2];
   int md_err[2];
   bit md_mm[2];
   bit md_ffv[2];
   int md_ffi[2];
   int md_ffvec[2];

   // golden f for {a,b,s} = index
   logic [7:0] f_tbl = 8'b1101_1000;

   always #5 clk = ~clk;

   mux_response_checker u_main (
      .clk(clk), .rst_n(rst_n), .start(start), .sample_valid(sample_valid),
      .a(a), .b(b), .s(s), .f(f),
      .busy(m_busy), .done(m_done), .pass(m_pass),
      .vec_count(m_vec), .err_count(m_err), .mismatch(m_mismatch)
`ifdef MUX_CHECK_FIRST_FAIL_EN
      , .first_fail_valid(m_ffv), .first_fail_idx(m_ffi), .first_fail_vec(m_ffvec)
`endif
   );

   mux_response_checker #(.NUM_VECTORS(7), .CNT_W(3)) u_tiny (
      .clk(clk), .rst_n(rst_n), .start(start), .sample_valid(sample_valid),
      .a(a), .b(b), .s(s), .f(f),
      .busy(t_busy), .done(t_done), .pass(t_pass),
      .vec_count(t_vec), .err_count(t_err), .mismatch(t_mismatch)
`ifdef MUX_CHECK_FIRST_FAIL_EN
      , .first_fail_valid(t_ffv), .first_fail_idx(t_ffi), .first_fail_vec(t_ffvec)
`endif
   );

   task automatic cmp(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         md_run[k] = 0; md_fin[k] = 0; md_vec[k] = 0; md_err[k] = 0;
         md_mm[k] = 0; md_ffv[k] = 0; md_ffi[k] = 0; md_ffvec[k] = 0;
      end
   endtask

   task automatic model_step(input bit st, input bit v, input bit aa, input bit bb,
                             input bit ss, input bit ff);
      for (int k = 0; k < 2; k++) begin
         bit bad;
         bad = (ff != (ss ? bb : aa));
         if (!md_run[k]) begin
            md_mm[k] = 0;
            if (st) begin
               md_run[k] = 1; md_fin[k] = 0; md_vec[k] = 0; md_err[k] = 0;
               md_ffv[k] = 0; md_ffi[k] = 0; md_ffvec[k] = 0;
            end
         end else if (v) begin
            md_mm[k] = bad;
            if (bad && !md_ffv[k]) begin
               md_ffv[k] = 1; md_ffi[k] = md_vec[k]; md_ffvec[k] = int'({aa, bb, ss, ff});
            end
            if (bad && md_err[k] < CAP[k]) md_err[k]++;
            md_vec[k]++;
            if (md_vec[k] == NV[k]) begin
               md_run[k] = 0; md_fin[k] = 1;
            end
         end else begin
            md_mm[k] = 0;
         end
      end
   endtask

   // apply one cycle of stimulus at the falling edge; model predicts the next rising edge
   task automatic drive(input bit st, input bit v, input bit aa, input bit bb,
                        input bit ss, input bit ff);
      @(negedge clk);
      start = st; sample_valid = v; a = aa; b = bb; s = ss; f = ff;
      model_step(st, v, aa, bb, ss, ff);
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   always @(posedge clk) begin
      #1;
      if (check_en) begin
         cmp("main.busy", m_busy, md_run[0]);
         cmp("main.done", m_done, md_fin[0]);
         cmp("main.pass", m_pass, md_fin[0] && md_err[0] == 0);
         cmp("main.vec_count", m_vec, md_vec[0]);
         cmp("main.err_count", m_err, md_err[0]);
         cmp("main.mismatch", m_mismatch, md_mm[0]);
         cmp("tiny.busy", t_busy, md_run[1]);
         cmp("tiny.done", t_done, md_fin[1]);
         cmp("tiny.pass", t_pass, md_fin[1] && md_err[1] == 0);
         cmp("tiny.vec_count", t_vec, md_vec[1]);
         cmp("tiny.err_count", t_err, md_err[1]);
         cmp("tiny.mismatch", t_mismatch, md_mm[1]);
`ifdef MUX_CHECK_FIRST_FAIL_EN
         cmp("main.first_fail_valid", m_ffv, md_ffv[0]);
         cmp("main.first_fail_idx", m_ffi, md_ffi[0]);
         cmp("main.first_fail_vec", m_ffvec, md_ffvec[0]);
         cmp("tiny.first_fail_valid", t_ffv, md_ffv[1]);
         cmp("tiny.first_fail_idx", t_ffi, md_ffi[1]);
         cmp("tiny.first_fail_vec", t_ffvec, md_ffvec[1]);
`endif
         if (m_mismatch) mm_count++;
      end
   end

   // mode: 0 clean, 1 bad at 3 and 10, 2 all bad, 3 valid toggling, 4 start at 12, 5 bad at 0
   task automatic run_samples(input int n, input int mode);
      drive(1, 1, 1, 1, 1, 0);
      settle();
      cmp("start.done_cleared", m_done, 0);
      cmp("start.vec_cleared", m_vec, 0);
      cmp("start.busy", m_busy, 1);
      mm_count = 0;
      for (int i = 0; i < n; i++) begin
         logic [2:0] abs_v;
         bit fe, bad, st;
         abs_v = 3'(i % 8);
         if (mode == 1 && (i == 3 || i == 10)) abs_v = 3'b100;
         fe = f_tbl[abs_v];
         bad = (mode == 2) || (mode == 1 && (i == 3 || i == 10)) || (mode == 5 && i == 0);
         st = (mode == 4 && i == 12);
         if (mode == 3) drive(0, 0, 1, 0, 0, 0);
         drive(st, 1, abs_v[2], abs_v[1], abs_v[0], bad ? ~fe : fe);
      end
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      cmp("reset.busy", m_busy, 0);
      cmp("reset.done", m_done, 0);
      cmp("reset.pass", m_pass, 0);
      cmp("reset.vec_count", m_vec, 0);
      cmp("reset.err_count", m_err, 0);
      cmp("reset.mismatch", m_mismatch, 0);
      @(negedge clk);
      rst_n = 1'b1;
      check_en = 1'b1;

      // idle samples are ignored
      drive(0, 1, 0, 0, 1, 1);
      drive(0, 1, 1, 0, 0, 0);

      run_samples(26, 0);
      settle();
      cmp("clean.done", m_done, 1);
      cmp("clean.pass", m_pass, 1);
      cmp("clean.vec_count", m_vec, 26);
      cmp("clean.err_count", m_err, 0);
      cmp("clean.mismatch_pulses", mm_count, 0);
      cmp("clean.tiny_vec", t_vec, 7);

      for (int i = 0; i < 3; i++) drive(0, 1, 0, 1, 1, 0);
      settle();
      cmp("done_frozen.vec_count", m_vec, 26);

      run_samples(26, 1);
      settle();
      cmp("err2.err_count", m_err, 2);
      cmp("err2.pass", m_pass, 0);
      cmp("err2.done", m_done, 1);
      cmp("err2.mismatch_pulses", mm_count, 2);
`ifdef MUX_CHECK_FIRST_FAIL_EN
      cmp("err2.first_fail_idx", m_ffi, 3);
      cmp("err2.first_fail_vec", m_ffvec, 4'b1000);
`endif

      run_samples(26, 3);
      settle();
      cmp("toggle.vec_count", m_vec, 26);
      cmp("toggle.done", m_done, 1);

      run_samples(26, 4);
      settle();
      cmp("restart_ignored.vec_count", m_vec, 26);
      cmp("restart_ignored.done", m_done, 1);

      run_samples(26, 2);
      settle();
      cmp("allbad.tiny_err", t_err, 7);
      cmp("allbad.tiny_pass", t_pass, 0);
      cmp("allbad.tiny_done", t_done, 1);
      cmp("allbad.main_err", m_err, 26);

      run_samples(15, 5);
      settle();
      cmp("midrun.err_count", m_err, 1);
      cmp("midrun.vec_count", m_vec, 15);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      start = 0; sample_valid = 0;
      model_reset();
      #1;
      cmp("async_rst.busy", m_busy, 0);
      cmp("async_rst.vec_count", m_vec, 0);
      cmp("async_rst.err_count", m_err, 0);
      cmp("async_rst.done", t_done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(0, 1, 1, 1, 0, 0);
      drive(0, 1, 0, 0, 0, 1);
      settle();
      cmp("post_rst.busy", m_busy, 0);
      cmp("post_rst.vec_count", m_vec, 0);

      run_samples(26, 0);
      drive(0, 0, 0, 0, 0, 0);
      settle();
      cmp("final.pass", m_pass, 1);

      check_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
